// File: rtl/pim_arith_pkg.sv
// Shared definitions for the PIM arithmetic cells.
//   div_state_e : sequential divider FSM encoding
//   DBZ_Q_ALL   : quotient returned on divide-by-zero (all ones, sliced to N)
//   cnt_w()     : width of a counter that must hold 0..n-1
package pim_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam logic [15:0] DBZ_Q_ALL = '1;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_seq_4bit_if.sv
// Handshake bundle for the sequential divider.
//   request : in_valid / in_ready, A (dividend), B (divisor)
//   response: out_valid / out_ready, Q, R, div_by_zero
// master = producer of operands / consumer of results, slave = divider.
interface div_seq_4bit_if #(parameter int N = 4);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         div_by_zero;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Q, R, div_by_zero
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Q, R, div_by_zero
  );
endinterface

// File: rtl/adder_nbit.sv
// Plain W-bit ripple adder with carry in/out.
//   a, b : addends      cin  : carry in
//   sum  : W-bit sum    cout : carry out
module adder_nbit #(parameter int W = 5) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/div_step_nbit.sv
// One restoring-division step (combinational).
//   rem      : current partial remainder (always < B)
//   a_bit    : next dividend bit, MSB first
//   B        : divisor
//   rem_next : partial remainder after this step
//   q_bit    : quotient bit produced by this step
module div_step_nbit #(parameter int N = 4) (
  input  logic [N-1:0] rem,
  input  logic         a_bit,
  input  logic [N-1:0] B,
  output logic [N-1:0] rem_next,
  output logic         q_bit
);
  logic [N:0] x, trial;
  logic       cout;

  assign x = {rem, a_bit};

  // x - B as x + ~B + 1 over N+1 bits
  adder_nbit #(.W(N+1)) u_sub (
    .a    (x),
    .b    (~{1'b0, B}),
    .cin  (1'b1),
    .sum  (trial),
    .cout (cout)
  );

  // With rem < B, x <= 2B-1, so carry-out and a clear sign bit agree on
  // "no borrow"; the restored value always fits N bits.
  assign q_bit    = cout & ~trial[N];
  assign rem_next = q_bit ? trial[N-1:0] : x[N-1:0];
endmodule

// File: rtl/div_seq_4bit.sv
// Sequential restoring unsigned divider, one quotient bit per cycle.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of div_seq_4bit_if (operands in, Q/R/div_by_zero out)
// Accept -> N CALC cycles -> DONE held until out_ready. B==0 skips CALC.
module div_seq_4bit
  import pim_arith_pkg::*;
#(parameter int N = 4) (
  input  logic          clk,
  input  logic          rst_n,
  div_seq_4bit_if.slave bus
);
  localparam int            CW   = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  div_state_e    state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_sh, b_reg, rem, q_sh;
  logic [N-1:0]  q_o, r_o, rem_nx;
  logic          dbz_o, rdy, q_bit, acc, hs;

  assign acc = bus.in_valid && rdy;
  assign hs  = bus.out_ready && (state == ST_DONE);

  div_step_nbit #(.N(N)) u_step (
    .rem      (rem),
    .a_bit    (a_sh[N-1]),
    .B        (b_reg),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (acc) state_nx = (bus.B == '0) ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == LAST) state_nx = ST_DONE;
      ST_DONE: if (hs) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // in_ready is registered so it stays low through reset and only rises
  // on the first edge after release.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdy <= 1'b0;
    else        rdy <= (state_nx == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_sh  <= '0;
      b_reg <= '0;
      rem   <= '0;
      q_sh  <= '0;
      q_o   <= '0;
      r_o   <= '0;
      dbz_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (acc) begin
          a_sh  <= bus.A;
          b_reg <= bus.B;
          rem   <= '0;
          cnt   <= '0;
          q_sh  <= '0;
          if (bus.B == '0) begin
            q_o   <= DBZ_Q_ALL[N-1:0];
            r_o   <= bus.A;
            dbz_o <= 1'b1;
          end
        end
        ST_CALC: begin
          a_sh <= {a_sh[N-2:0], 1'b0};
          rem  <= rem_nx;
          q_sh <= {q_sh[N-2:0], q_bit};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            q_o <= {q_sh[N-2:0], q_bit};
            r_o <= rem_nx;
          end
        end
        ST_DONE: if (hs) begin
          // results read as zero everywhere outside DONE
          q_o   <= '0;
          r_o   <= '0;
          dbz_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = rdy;
  assign bus.out_valid   = (state == ST_DONE);
  assign bus.Q           = q_o;
  assign bus.R           = r_o;
  assign bus.div_by_zero = dbz_o;
endmodule

// File: tb/tb_div_seq_4bit.sv
// Directed bench for div_seq_4bit (N=4): handshake timing, divide-by-zero,
// back-to-back, output stall, mid-op reset, and a full 16x16 sweep.
module tb_div_seq_4bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0, n_pass = 0;

  div_seq_4bit_if #(.N(4)) bus ();

  div_seq_4bit #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] mul_partial(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'(a) * 8'(b);
    return p[3:0];
  endfunction

  // Drive one operation and return the result, optionally with random stalls.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit stall,
                        output logic [3:0] q, output logic [3:0] r, output logic z);
    int n;
    logic go;
    q = '0; r = '0; z = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 20) begin tick; n++; end
    if (!bus.in_ready) begin chk("tmo_in_ready", 32'd0, 32'd1); return; end
    bus.A = a; bus.B = b; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    bus.A = 4'($urandom); bus.B = 4'($urandom);
    n = 0;
    while (!bus.out_valid && n < 20) begin tick; n++; end
    if (!bus.out_valid) begin chk("tmo_out_valid", 32'd0, 32'd1); return; end
    q = bus.Q; r = bus.R; z = bus.div_by_zero;
    n = 0;
    forever begin
      if (bus.Q !== q || bus.R !== r) chk("stall_hold", 32'({bus.Q, bus.R}), 32'({q, r}));
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      go = bus.out_ready;
      tick;
      if (go) break;
      n++;
      if (n > 40) begin chk("tmo_out_hs", 32'd0, 32'd1); break; end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] q, r;
    logic       z, saw_ov;
    logic [4:0] eq;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.A = '0; bus.B = '0;

    // reset state
    #3;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_qrz", 32'({bus.Q, bus.R, bus.div_by_zero}), 32'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // 13/3, latency and in_ready timing
    bus.A = 4'd13; bus.B = 4'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (k == 1) bus.in_valid = 1'b0;
      chk($sformatf("t1_ov_c%0d", k), 32'(bus.out_valid), 32'(k == 5));
      chk($sformatf("t1_ir_c%0d", k), 32'(bus.in_ready), 32'(k == 6));
      if (k == 5) begin
        chk("t1_q", 32'(bus.Q), 32'd4);
        chk("t1_r", 32'(bus.R), 32'd1);
        chk("t1_dbz", 32'(bus.div_by_zero), 32'd0);
      end
    end

    // 7/0 -> divide by zero, result in cycle 1
    bus.A = 4'd7; bus.B = 4'd0; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    chk("t2_ov", 32'(bus.out_valid), 32'd1);
    chk("t2_q", 32'(bus.Q), 32'd15);
    chk("t2_r", 32'(bus.R), 32'd7);
    chk("t2_dbz", 32'(bus.div_by_zero), 32'd1);
    tick;
    chk("t2_ov_off", 32'(bus.out_valid), 32'd0);
    chk("t2_dbz_off", 32'(bus.div_by_zero), 32'd0);
    chk("t2_ir", 32'(bus.in_ready), 32'd1);

    // 15/1 then 2/9 with in_valid held high
    bus.A = 4'd15; bus.B = 4'd1; bus.in_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (k == 1) begin bus.A = 4'd2; bus.B = 4'd9; end
      if (k == 7) bus.in_valid = 1'b0;
      chk($sformatf("t3_ir_c%0d", k), 32'(bus.in_ready), 32'(k == 6 || k == 12));
      chk($sformatf("t3_ov_c%0d", k), 32'(bus.out_valid), 32'(k == 5 || k == 11));
      if (k == 5) chk("t3_qr0", 32'({bus.Q, bus.R}), 32'({4'd15, 4'd0}));
      if (k == 11) chk("t3_qr1", 32'({bus.Q, bus.R}), 32'({4'd0, 4'd2}));
    end

    // 9/4 with out_ready low in cycles 5..7, operands scrambled after accept
    bus.out_ready = 1'b0;
    bus.A = 4'd9; bus.B = 4'd4; bus.in_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick;
      if (k == 1) bus.in_valid = 1'b0;
      bus.A = 4'($urandom); bus.B = 4'($urandom);
      if (k >= 5 && k <= 8) begin
        chk($sformatf("t4_ov_c%0d", k), 32'(bus.out_valid), 32'd1);
        chk($sformatf("t4_qr_c%0d", k), 32'({bus.Q, bus.R}), 32'({4'd2, 4'd1}));
        chk($sformatf("t4_ir_c%0d", k), 32'(bus.in_ready), 32'd0);
      end
      if (k == 8) bus.out_ready = 1'b1;
      if (k == 9) begin
        chk("t4_ov_off", 32'(bus.out_valid), 32'd0);
        chk("t4_q_zero", 32'(bus.Q), 32'd0);
        chk("t4_ir", 32'(bus.in_ready), 32'd1);
      end
    end
    bus.out_ready = 1'b0;

    // 14/5 aborted by reset in cycle 2, then redone
    bus.A = 4'd14; bus.B = 4'd5; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ir", 32'(bus.in_ready), 32'd0);
    chk("t5_rst_ov", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_qr", 32'({bus.Q, bus.R, bus.div_by_zero}), 32'd0);
    tick; tick;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    saw_ov = 1'b0;
    for (int k = 0; k < 8; k++) begin tick; saw_ov |= bus.out_valid; end
    chk("t5_no_ov", 32'(saw_ov), 32'd0);
    bus.out_ready = 1'b0;
    run_op(4'd14, 4'd5, 1'b0, q, r, z);
    chk("t5_qr", 32'({q, r, z}), 32'({4'd2, 4'd4, 1'b0}));

    // exhaustive sweep with random out_ready stalls
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), 1'b1, q, r, z);
        if (b == 0) begin
          chk($sformatf("sw_dbz_%0d", a), 32'({q, r, z}), 32'({4'd15, 4'(a), 1'b1}));
        end else begin
          chk($sformatf("sw_q_%0d_%0d", a, b), 32'(q), 32'(a / b));
          chk($sformatf("sw_r_%0d_%0d", a, b), 32'(r), 32'(a % b));
          chk($sformatf("sw_z_%0d_%0d", a, b), 32'(z), 32'd0);
          chk($sformatf("sw_id_%0d_%0d", a, b), 32'(q) * 32'(b) + 32'(r), 32'(a));
          chk($sformatf("sw_rlt_%0d_%0d", a, b), 32'(32'(r) < 32'(b)), 32'd1);
          eq = 5'(mul_partial(q, 4'(b))) + 5'(r);
          chk($sformatf("sw_mp_%0d_%0d", a, b), 32'(eq[3:0]), 32'(a));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/div_seq_4bit.md
# div_seq_4bit

Sequential restoring unsigned divider, the inverse of the truncated and partial multiplier cells in the PIM arithmetic submodule set. It accepts a dividend/divisor pair over a valid/ready handshake and iterates one quotient bit per cycle. It returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake. It serves as the reference division unit for PIM datapaths, where `Q*B + R == A` cross-checks the multiplier cells.

## Interface
- `N`, default 4: operand width in bits; legal range 2..16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  dividend/divisor pair presented.
- `in_ready`  out  1  block can accept a pair.
- `A`  in  N  dividend, unsigned.
- `B`  in  N  divisor, unsigned.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `Q`  out  N  quotient.
- `R`  out  N  remainder.
- `div_by_zero`  out  1  set when the accepted `B` was 0.

## Operation
- FSM states are IDLE, CALC and DONE. Reset state is IDLE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid && in_ready`, latch `A` and `B`.
  - If `B==0`, go to DONE with `Q={N{1'b1}}`, `R=A` and `div_by_zero=1`.
  - Otherwise, clear the partial remainder (N+1 bits) and the step counter, then go to CALC.
- CALC runs exactly N cycles, one step per cycle, taking dividend bits MSB first:
  - `trial = {rem[N-1:0], a_bit} - {1'b0, B}`.
  - If `trial` is non-negative (MSB 0), then `rem = trial` and the quotient bit is 1.
  - Otherwise, `rem` shifts in `a_bit` and the quotient bit is 0.
  - After step N-1, go to DONE.
- DONE:
  - `out_valid=1`.
  - `Q`, `R` and `div_by_zero` are held stable until `out_valid && out_ready`, then the FSM returns to IDLE.
- `in_ready` is 0 in CALC and DONE. There is no overlap of operations.
- Arithmetic:
  - The subtraction uses N+1 bits. The borrow is the MSB.
  - Final `R < B` and `R` fits in N bits. `Q*B + R == A`, exact and untruncated.
- Inputs `A` and `B` are ignored when no handshake occurs. Changes to them after acceptance have no effect.

## Timing
- Reset values (async assert, immediate):
  - `in_ready=0` while `rst_n=0`, then 1 in IDLE from the first cycle after release.
  - `out_valid=0`, `Q=0`, `R=0`, `div_by_zero=0`.
- Let the accept edge be cycle 0.
- Normal latency:
  - CALC occupies cycles 1..N.
  - `out_valid` rises after edge N, i.e. visible in cycle N+1 (cycle 5 for N=4).
- Divide-by-zero latency: `out_valid` is visible in cycle 1.
- Throughput: at best one result per N+2 cycles with `out_ready` tied high. `in_ready` returns in the cycle after the output handshake.
- `out_ready` high while `out_valid` is low has no effect.
- Reset asserted mid-CALC or mid-DONE:
  - Aborts immediately.
  - The result is lost. No `out_valid` is produced for that operation.
  - All outputs return to their reset values.
- Outputs `Q` and `R` are registered. They are undefined-free: zero outside DONE.

## Structure
- Shared package `pim_arith_pkg` holds:
  - the FSM state encoding (`ST_IDLE`, `ST_CALC`, `ST_DONE`);
  - the divide-by-zero quotient constant (all ones);
  - a `clog2`-based counter width helper.
- One natural sub-module, `div_step_nbit`: combinational, one restoring step.
  - Inputs: `rem` (N bits), `a_bit`, `B`.
  - Outputs: `rem_next` (N bits), `q_bit`.
  - Its N+1-bit subtract is built from `adder_nbit` with B inverted and carry-in 1.
- The top holds the FSM, step counter, operand and quotient shift registers, and handshake logic.

## Test plan
- A=13, B=3, handshake at cycle 0, `out_ready=1` → Q=4, R=1, `div_by_zero=0`, `out_valid` in cycle 5 only; `in_ready` low in cycles 1..5 and high in cycle 6.
- A=7, B=0 → Q=15, R=7, `div_by_zero=1`, `out_valid` in cycle 1.
- A=15, B=1 and then A=2, B=9 back-to-back → Q=15, R=0, then Q=0, R=2. The second pair is accepted only when `in_ready` is high; `in_valid` held high meanwhile.
- A=9, B=4 with `out_ready` low for 3 cycles after `out_valid` → Q=2, R=1 held stable, `in_ready=0`, and changing `A` and `B` has no effect; release gives one handshake.
- `rst_n` pulsed low in cycle 2 of A=14, B=5 → outputs zero immediately, no `out_valid`; a next op A=14, B=5 gives Q=2, R=4.
- Exhaustive sweep over all 256 (A, B) pairs with random `out_ready` stalls: for B≠0, `Q*B+R==A` and `R<B`; `mul_partial_4bit(Q,B)+R` equals A mod 16.
